// File: rtl/line_fetcher_if.sv
// Wishbone read-only bus between the line fetcher (master) and video memory (slave).
interface line_fetcher_if #(
    parameter int ADR_W = 24
);
    logic             cyc;
    logic             stb;
    logic [ADR_W-1:0] adr;
    logic [15:0]      dat;
    logic             ack;

    modport master (output cyc, stb, adr, input dat, ack);
    modport slave  (input cyc, stb, adr, output dat, ack);
endinterface

// File: rtl/line_fetcher.sv
// Scanline fetcher: bursts WORDS_I 16-bit words from video memory into a line buffer.
// Optional build macro LINE_FETCHER_ABORT_EN adds abort_i to cancel a fetch in progress.
module line_fetcher #(
    parameter int ADR_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [ADR_W-1:0] base_adr_i,
    input  logic [8:0]       words_i,
`ifdef LINE_FETCHER_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    line_fetcher_if.master   m_bus,
    output logic [8:0]       s_adr_o,
    output logic [15:0]      s_dat_o,
    output logic             s_we_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [8:0]       idx_q, idx_d;
    logic [8:0]       words_q, words_d;
    logic             cyc_q, cyc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic [8:0]       s_adr_q, s_adr_d;
    logic [15:0]      s_dat_q, s_dat_d;
    logic [8:0]       idx_inc_s;
    logic             abort_s;

`ifdef LINE_FETCHER_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    assign idx_inc_s = idx_q + 9'd1;

    // Next-state and output-register logic for the fetch FSM.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        idx_d   = idx_q;
        words_d = words_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        s_adr_d = s_adr_q;
        s_dat_d = s_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (words_i != 9'd0) begin
                        state_d = ST_FETCH;
                        adr_d   = base_adr_i;
                        idx_d   = 9'd0;
                        words_d = words_i;
                        cyc_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty line: acknowledge without touching the bus.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (m_bus.ack) begin
                    adr_d   = adr_q + ADR_W'(1'b1);
                    idx_d   = idx_inc_s;
                    we_d    = 1'b1;
                    s_adr_d = idx_q;
                    s_dat_d = m_bus.dat;
                    if (idx_inc_s == words_q) begin
                        state_d = ST_FINISH;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            idx_q   <= 9'd0;
            words_q <= 9'd0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            s_adr_q <= 9'd0;
            s_dat_q <= 16'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            s_adr_q <= s_adr_d;
            s_dat_q <= s_dat_d;
        end
    end

    assign m_bus.cyc = cyc_q;
    assign m_bus.stb = cyc_q;
    assign m_bus.adr = adr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign s_we_o    = we_q;
    assign s_adr_o   = s_adr_q;
    assign s_dat_o   = s_dat_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Directed self-checking bench for line_fetcher; abort scenario enabled with LINE_FETCHER_ABORT_EN.
module tb_line_fetcher;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] base;
    logic [8:0]  words;
    logic        busy;
    logic        done;
    logic [8:0]  s_adr;
    logic [15:0] s_dat;
    logic        s_we;
`ifdef LINE_FETCHER_ABORT_EN
    logic        abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    line_fetcher_if #(.ADR_W(24)) bus ();

    line_fetcher #(.ADR_W(24)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .base_adr_i (base),
        .words_i    (words),
`ifdef LINE_FETCHER_ABORT_EN
        .abort_i    (abort),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .m_bus      (bus.master),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat),
        .s_we_o     (s_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dat_of(input int k);
        logic [15:0] kk;
        kk = 16'(k + 1);
        return 16'(16'h1111 * kk);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_cyc"},  32'(bus.cyc), 32'd0);
        check_eq({tag, "_stb"},  32'(bus.stb), 32'd0);
        check_eq({tag, "_adr"},  32'(bus.adr), 32'd0);
        check_eq({tag, "_we"},   32'(s_we), 32'd0);
        check_eq({tag, "_sadr"}, 32'(s_adr), 32'd0);
        check_eq({tag, "_sdat"}, 32'(s_dat), 32'd0);
    endtask

    // Full fetch: ACK every 'period' cycles, optional START re-pulse mid-fetch.
    task automatic run_fetch(input logic [23:0] b, input logic [8:0] w, input int period,
                             input bit repulse, input string tag);
        int acks;
        int writes;
        int dones;
        int c;
        logic [23:0] exp_adr;
        acks = 0; writes = 0; dones = 0; c = 0;
        @(negedge clk);
        start = 1'b1; base = b; words = w;
        @(negedge clk);
        start = 1'b0;
        while (dones == 0 && c < 200) begin
            if (s_we) begin
                check_eq({tag, "_wadr"}, 32'(s_adr), 32'(writes));
                check_eq({tag, "_wdat"}, 32'(s_dat), 32'(dat_of(writes)));
                writes++;
            end
            if (done) begin
                dones++;
                check_eq({tag, "_done_we"},   32'(s_we), 32'd1);
                check_eq({tag, "_done_busy"}, 32'(busy), 32'd1);
                check_eq({tag, "_done_cyc"},  32'(bus.cyc), 32'd0);
                bus.ack = 1'b0;
                start   = 1'b0;
            end else begin
                exp_adr = b + 24'(acks);
                check_eq({tag, "_cyc"},  32'(bus.cyc), 32'd1);
                check_eq({tag, "_stb"},  32'(bus.stb), 32'd1);
                check_eq({tag, "_madr"}, 32'(bus.adr), 32'(exp_adr));
                start = (repulse && c == 1);
                if (start) begin
                    base  = 24'h000100;
                    words = 9'd7;
                end
                bus.ack = ((c % period) == period - 1);
                bus.dat = bus.ack ? dat_of(acks) : 16'hDEAD;
                if (bus.ack) acks++;
            end
            c++;
            @(negedge clk);
        end
        check_eq({tag, "_timeout"}, 32'(c < 200), 32'd1);
        check_eq({tag, "_nwrites"}, 32'(writes), 32'(w));
        check_eq({tag, "_ndone"},   32'(dones), 32'd1);
        check_eq({tag, "_post_done"}, 32'(done), 32'd0);
        check_eq({tag, "_post_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_post_cyc"},  32'(bus.cyc), 32'd0);
        check_eq({tag, "_post_we"},   32'(s_we), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = 24'd0; words = 9'd0;
        bus.ack = 1'b0; bus.dat = 16'd0;
`ifdef LINE_FETCHER_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_fetch(24'h001000, 9'd4, 1, 1'b0, "zero_wait");
        run_fetch(24'h001000, 9'd3, 3, 1'b0, "wait_st");

        // Degenerate fetch: DONE one cycle after START, bus untouched.
        @(negedge clk);
        start = 1'b1; base = 24'h123456; words = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_cyc",  32'(bus.cyc), 32'd0);
        check_eq("zero_busy", 32'(busy), 32'd0);
        check_eq("zero_we",   32'(s_we), 32'd0);
        @(negedge clk);
        check_eq("zero_done_end", 32'(done), 32'd0);
        check_eq("zero_cyc_end",  32'(bus.cyc), 32'd0);

        // ACK while idle must be ignored.
        bus.ack = 1'b1; bus.dat = 16'hBEEF;
        @(negedge clk);
        check_eq("idle_ack_we",  32'(s_we), 32'd0);
        check_eq("idle_ack_cyc", 32'(bus.cyc), 32'd0);
        bus.ack = 1'b0;

        run_fetch(24'hFFFFFF, 9'd2, 1, 1'b1, "wrap");

        // Reset after 2 of 5 ACKs.
        @(negedge clk);
        start = 1'b1; base = 24'h002000; words = 9'd5;
        @(negedge clk);
        start = 1'b0; bus.ack = 1'b1; bus.dat = 16'hA0A0;
        @(negedge clk);
        bus.dat = 16'hA1A1;
        @(negedge clk);
        check_eq("rst_mid_we",   32'(s_we), 32'd1);
        check_eq("rst_mid_sadr", 32'(s_adr), 32'd1);
        check_eq("rst_mid_cyc",  32'(bus.cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold_done", 32'(done), 32'd0);
            check_eq("rst_hold_we",   32'(s_we), 32'd0);
            check_eq("rst_hold_cyc",  32'(bus.cyc), 32'd0);
        end
        rst_n = 1'b1; bus.ack = 1'b0;
        run_fetch(24'h002000, 9'd5, 1, 1'b0, "post_rst");

`ifdef LINE_FETCHER_ABORT_EN
        // Abort together with the 2nd ACK of 5.
        @(negedge clk);
        start = 1'b1; base = 24'h003000; words = 9'd5;
        @(negedge clk);
        start = 1'b0; bus.ack = 1'b1; bus.dat = 16'h1111;
        @(negedge clk);
        check_eq("abort_w0_we",   32'(s_we), 32'd1);
        check_eq("abort_w0_sadr", 32'(s_adr), 32'd0);
        bus.dat = 16'h2222; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; bus.ack = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_we",   32'(s_we), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_cyc",  32'(bus.cyc), 32'd0);
        @(negedge clk);
        check_eq("abort_we2",   32'(s_we), 32'd0);
        check_eq("abort_done2", 32'(done), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
